// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter
// Schedules single SDRAM bursts between the camera write FIFO and the VGA
// read FIFO, and ping-pongs two frame banks so the display side always
// reads the most recently completed camera frame.
//
// Command handshake: when a burst is granted, cmd_req rises with cmd_wr and
// cmd_addr. All three hold steady until cmd_ack is sampled high. cmd_req
// drops on the following cycle and the arbiter waits for a one-cycle
// cmd_done pulse. Only one burst is outstanding at a time. cmd_done is
// ignored unless a burst is waiting for it.
module sdram_burst_arbiter #(
    parameter int BURST_LEN   = 256,
    parameter int FIFO_DEPTH  = 1024,
    parameter int FIFO_AW     = 10,
    parameter int ADDR_W      = 22,
    parameter int FRAME_WORDS = 307200,
    parameter int RD_LOW      = 128
) (
    input  logic                clk_ref,
    input  logic                rst_n,
    input  logic                sdram_init_done,
    input  logic                wr_frame_start,
    input  logic                rd_frame_start,
    input  logic [FIFO_AW:0]    wr_fifo_used,
    input  logic [FIFO_AW:0]    rd_fifo_used,
    output logic                cmd_req,
    output logic                cmd_wr,
    output logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_ack,
    input  logic                cmd_done,
    output logic                wr_overflow,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int OFF_W    = ADDR_W - 1;
    localparam int RD_THR_I = FIFO_DEPTH - BURST_LEN;

    localparam logic [FIFO_AW:0] BURST_USED  = BURST_LEN[FIFO_AW:0];
    localparam logic [FIFO_AW:0] RD_THR      = RD_THR_I[FIFO_AW:0];
    localparam logic [FIFO_AW:0] RD_LOW_USED = RD_LOW[FIFO_AW:0];
    localparam logic [OFF_W-1:0] OFF_STEP    = BURST_LEN[OFF_W-1:0];
    localparam logic [OFF_W-1:0] FRAME_END   = FRAME_WORDS[OFF_W-1:0];

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_REQ  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t           state;
    logic             wr_bank;
    logic             rd_bank;
    logic             done_bank;
    logic [OFF_W-1:0] wr_off;
    logic [OFF_W-1:0] rd_off;
    logic             last_grant_wr;
    logic             wr_pend;
    logic             rd_pend;

    logic             wr_pend_eff;
    logic             rd_pend_eff;
    logic             eff_wr_bank;
    logic             eff_done_bank;
    logic             eff_rd_bank;
    logic [OFF_W-1:0] eff_wr_off;
    logic [OFF_W-1:0] eff_rd_off;
    logic             wr_need;
    logic             rd_need;
    logic             rd_urgent;
    logic             grant_rd;
    logic             grant_wr;
    logic [OFF_W-1:0] wr_off_next;
    logic [OFF_W-1:0] rd_off_next;
    logic             wr_wrap;
    logic             rd_wrap;

    assign dbg_state = state;

    // Frame-bank view after pending frame starts are applied, plus arbitration
    always_comb begin
        wr_pend_eff   = wr_pend | wr_frame_start;
        rd_pend_eff   = rd_pend | rd_frame_start;
        eff_wr_bank   = wr_pend_eff ? ~wr_bank : wr_bank;
        eff_done_bank = wr_pend_eff ? wr_bank : done_bank;
        eff_rd_bank   = rd_pend_eff ? eff_done_bank : rd_bank;
        eff_wr_off    = wr_pend_eff ? '0 : wr_off;
        eff_rd_off    = rd_pend_eff ? '0 : rd_off;

        wr_need   = wr_fifo_used >= BURST_USED;
        rd_need   = rd_fifo_used <= RD_THR;
        rd_urgent = rd_need && (rd_fifo_used < RD_LOW_USED);
        // Urgent reads win outright; otherwise alternate when both want service
        grant_rd  = rd_urgent || (rd_need && (!wr_need || last_grant_wr));
        grant_wr  = wr_need && !grant_rd;

        wr_off_next = wr_off + OFF_STEP;
        rd_off_next = rd_off + OFF_STEP;
        wr_wrap     = (wr_off_next == FRAME_END);
        rd_wrap     = (rd_off_next == FRAME_END);
    end

    // Main scheduler: state, frame bookkeeping and registered command outputs
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            cmd_req       <= 1'b0;
            cmd_wr        <= 1'b0;
            cmd_addr      <= '0;
            busy          <= 1'b0;
            wr_overflow   <= 1'b0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b1;
            done_bank     <= 1'b1;
            wr_off        <= '0;
            rd_off        <= '0;
            last_grant_wr <= 1'b0;
            wr_pend       <= 1'b0;
            rd_pend       <= 1'b0;
        end else begin
            wr_overflow <= 1'b0;
            case (state)
                ST_INIT: begin
                    wr_pend <= wr_pend_eff;
                    rd_pend <= rd_pend_eff;
                    if (sdram_init_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    // Frame starts only ever take effect between bursts
                    wr_pend   <= 1'b0;
                    rd_pend   <= 1'b0;
                    wr_bank   <= eff_wr_bank;
                    done_bank <= eff_done_bank;
                    rd_bank   <= eff_rd_bank;
                    wr_off    <= eff_wr_off;
                    rd_off    <= eff_rd_off;
                    if (!sdram_init_done) begin
                        state <= ST_INIT;
                    end else if (grant_rd) begin
                        cmd_req       <= 1'b1;
                        cmd_wr        <= 1'b0;
                        cmd_addr      <= {eff_rd_bank, eff_rd_off};
                        last_grant_wr <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ST_REQ;
                    end else if (grant_wr) begin
                        cmd_req       <= 1'b1;
                        cmd_wr        <= 1'b1;
                        cmd_addr      <= {eff_wr_bank, eff_wr_off};
                        last_grant_wr <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    wr_pend <= wr_pend_eff;
                    rd_pend <= rd_pend_eff;
                    if (cmd_ack) begin
                        cmd_req <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wr_pend <= wr_pend_eff;
                    rd_pend <= rd_pend_eff;
                    if (cmd_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                        if (cmd_wr) begin
                            wr_off      <= wr_wrap ? '0 : wr_off_next;
                            wr_overflow <= wr_wrap;
                        end else begin
                            rd_off <= rd_wrap ? '0 : rd_off_next;
                        end
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Testbench for sdram_burst_arbiter: acts as the SDRAM controller and both
// FIFOs, predicting every granted burst from a transaction-level model.
`timescale 1ns/1ps
module tb_sdram_burst_arbiter;

    localparam int BURST  = 256;
    localparam int FRAME  = 307200;
    localparam int BANK_W = 1 << 21;

    // ---------------- clock / reset ----------------
    logic        clk_ref = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic        wr_frame_start;
    logic        rd_frame_start;
    logic [10:0] wr_fifo_used;
    logic [10:0] rd_fifo_used;
    logic        cmd_req;
    logic        cmd_wr;
    logic [21:0] cmd_addr;
    logic        cmd_ack;
    logic        cmd_done;
    logic        wr_overflow;
    logic        busy;
    logic [1:0]  dbg_state;

    always #5 clk_ref = ~clk_ref;

    sdram_burst_arbiter dut (
        .clk_ref         (clk_ref),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wr_frame_start  (wr_frame_start),
        .rd_frame_start  (rd_frame_start),
        .wr_fifo_used    (wr_fifo_used),
        .rd_fifo_used    (rd_fifo_used),
        .cmd_req         (cmd_req),
        .cmd_wr          (cmd_wr),
        .cmd_addr        (cmd_addr),
        .cmd_ack         (cmd_ack),
        .cmd_done        (cmd_done),
        .wr_overflow     (wr_overflow),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int ovf_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_addr;
    logic        last_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_wr_bank, m_rd_bank, m_done_bank;
    int m_wr_off, m_rd_off;
    bit m_last_wr, m_wr_pend, m_rd_pend;

    task automatic model_reset();
        m_wr_bank = 0; m_rd_bank = 1; m_done_bank = 1;
        m_wr_off = 0; m_rd_off = 0;
        m_last_wr = 0; m_wr_pend = 0; m_rd_pend = 0;
    endtask

    // Decide the next burst from FIFO levels; frame starts apply lazily here
    task automatic model_grant(input int wu, input int ru, output bit wr, output int addr, output bit any);
        bit wn, rn;
        if (m_wr_pend) begin
            m_done_bank = m_wr_bank;
            m_wr_bank   = 1 - m_wr_bank;
            m_wr_off    = 0;
            m_wr_pend   = 0;
        end
        if (m_rd_pend) begin
            m_rd_bank = m_done_bank;
            m_rd_off  = 0;
            m_rd_pend = 0;
        end
        wn  = (wu >= BURST);
        rn  = (ru <= 1024 - BURST);
        any = 1;
        wr  = 0;
        if (rn && ru < 128)  wr = 0;
        else if (wn && rn)   wr = !m_last_wr;
        else if (wn)         wr = 1;
        else if (rn)         wr = 0;
        else                 any = 0;
        addr = wr ? m_wr_bank * BANK_W + m_wr_off : m_rd_bank * BANK_W + m_rd_off;
        if (any) m_last_wr = wr;
    endtask

    task automatic model_done(input bit wr, output bit wrap);
        wrap = 0;
        if (wr) begin
            m_wr_off += BURST;
            if (m_wr_off == FRAME) begin m_wr_off = 0; wrap = 1; end
        end else begin
            m_rd_off += BURST;
            if (m_rd_off == FRAME) m_rd_off = 0;
        end
    endtask

    // Per-cycle output comparison against model expectation
    task automatic per_cycle(input bit exp_busy, input bit exp_ovf);
        check("busy", 32'(busy), 32'(exp_busy));
        check("wr_overflow", 32'(wr_overflow), 32'(exp_ovf));
        if (wr_overflow) ovf_seen++;
    endtask

    // ---------------- driver ----------------
    task automatic run_burst(input int wu, input int ru, input bit pulse_wf, input bit pulse_rf, input bit drop_init);
        bit ew, any, wrap;
        int ea, n, ack_dly, done_dly;
        logic [31:0] exp_addr;
        wr_fifo_used = 11'(wu);
        rd_fifo_used = 11'(ru);
        model_grant(wu, ru, ew, ea, any);
        if (!any) begin
            repeat (4) begin
                @(negedge clk_ref);
                check("no_need_req", 32'(cmd_req), 32'd0);
                per_cycle(0, 0);
            end
            return;
        end
        exp_q.push_back(32'(ea));
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
            if (!cmd_req) per_cycle(0, 0);
        end while (!cmd_req && n < 8);
        check("req_timeout", 32'(cmd_req), 32'd1);
        exp_addr = exp_q.pop_front();
        if (!cmd_req) return;
        last_addr = 32'(cmd_addr);
        last_wr   = cmd_wr;
        ack_dly = $urandom_range(0, 3);
        for (int i = 0; i <= ack_dly; i++) begin
            if (i > 0) @(negedge clk_ref);
            check("req_held", 32'(cmd_req), 32'd1);
            check("cmd_wr", 32'(cmd_wr), 32'(ew));
            check("cmd_addr", 32'(cmd_addr), exp_addr);
            per_cycle(1, 0);
            // stray completion while still requesting must be ignored
            cmd_done = (i == 0 && ack_dly > 0);
        end
        cmd_done = 1'b0;
        cmd_ack  = 1'b1;
        @(negedge clk_ref);
        cmd_ack = 1'b0;
        check("req_drop", 32'(cmd_req), 32'd0);
        per_cycle(1, 0);
        if (pulse_wf) begin wr_frame_start = 1'b1; m_wr_pend = 1; end
        if (pulse_rf) begin rd_frame_start = 1'b1; m_rd_pend = 1; end
        if (drop_init) sdram_init_done = 1'b0;
        done_dly = $urandom_range(1, 4);
        for (int i = 0; i < done_dly; i++) begin
            @(negedge clk_ref);
            wr_frame_start = 1'b0;
            rd_frame_start = 1'b0;
            check("wait_no_req", 32'(cmd_req), 32'd0);
            per_cycle(1, 0);
        end
        cmd_done = 1'b1;
        @(negedge clk_ref);
        cmd_done = 1'b0;
        model_done(ew, wrap);
        check("post_done_req", 32'(cmd_req), 32'd0);
        per_cycle(0, wrap);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        wr_fifo_used = 11'd0;
        rd_fifo_used = 11'd1024;
        cmd_ack = 1'b0;
        cmd_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_ref);
        rst_n = 1'b1;
        @(negedge clk_ref);
        check("rst_cmd_req", 32'(cmd_req), 32'd0);
        check("rst_cmd_wr", 32'(cmd_wr), 32'd0);
        check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        per_cycle(0, 0);

        // nothing may be issued before controller init completes
        wr_fifo_used = 11'd512;
        repeat (6) begin
            @(negedge clk_ref);
            check("pre_init_req", 32'(cmd_req), 32'd0);
        end
        sdram_init_done = 1'b1;
        run_burst(512, 1024, 0, 0, 0);
        check("t1_addr", last_addr, 32'h000000);
        check("t1_wr", 32'(last_wr), 32'd1);

        run_burst(300, 1024, 0, 0, 0);
        check("t2_addr", last_addr, 32'h000100);

        // alternation when both sides need service
        run_burst(300, 500, 0, 0, 0);
        check("t3_rd0", last_addr, 32'h200000);
        check("t3_rd0_wr", 32'(last_wr), 32'd0);
        run_burst(300, 500, 0, 0, 0);
        check("t3_wr1", last_addr, 32'h000200);
        run_burst(300, 500, 0, 0, 0);
        check("t3_rd1", last_addr, 32'h200100);

        // urgent read wins even right after a read
        run_burst(1000, 100, 0, 0, 0);
        check("t4_urgent", last_addr, 32'h200200);
        check("t4_urgent_wr", 32'(last_wr), 32'd0);

        // neither side needs a burst
        run_burst(100, 900, 0, 0, 0);

        // frame starts during a burst take effect at the next idle
        run_burst(300, 1024, 1, 1, 0);
        check("t6_pre", last_addr, 32'h000300);
        run_burst(300, 1024, 0, 0, 0);
        check("t6_wr_bank1", last_addr, 32'h200000);
        run_burst(0, 500, 0, 0, 0);
        check("t6_rd_bank0", last_addr, 32'h000000);

        // init_done drop: burst completes, then nothing until init returns
        run_burst(300, 1024, 0, 0, 1);
        repeat (6) begin
            @(negedge clk_ref);
            check("init_drop_req", 32'(cmd_req), 32'd0);
        end
        sdram_init_done = 1'b1;
        run_burst(300, 1024, 0, 0, 0);
        check("init_back", last_addr, 32'h200200);

        // asynchronous reset in the middle of a burst
        wr_fifo_used = 11'd300;
        n = 0;
        do begin @(negedge clk_ref); n++; end while (!cmd_req && n < 8);
        check("mid_rst_req", 32'(cmd_req), 32'd1);
        cmd_ack = 1'b1;
        @(negedge clk_ref);
        cmd_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req0", 32'(cmd_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'(cmd_addr), 32'd0);
        model_reset();
        @(negedge clk_ref);
        rst_n = 1'b1;

        // a full frame of writes without a frame start wraps exactly once
        ovf_seen = 0;
        for (int i = 0; i < FRAME / BURST; i++) begin
            run_burst($urandom_range(256, 1024), 1024, 0, 0, 0);
        end
        check("t5_ovf_count", 32'(ovf_seen), 32'd1);
        run_burst(300, 1024, 0, 0, 0);
        check("t5_wrapped", last_addr, 32'h000000);

        // randomized traffic with occasional frame starts
        for (int i = 0; i < 300; i++) begin
            run_burst($urandom_range(0, 1024), $urandom_range(0, 1024),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
